// File: rtl/spram_arb_pkg.sv
// Shared constants for the round-robin arbiter in front of the 64x32 single-port SRAM.
package spram_arb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [BE_W-1:0] SRAM_IDLE_BWEB = {BE_W{1'b1}};

endpackage : spram_arb_pkg

// File: rtl/rr_arbiter.sv
// Round-robin grant generator; owns the "last granted" pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] win_idx_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Search last+1, last+2, ... (mod NUM_REQ) and grant the first requester found
    always_comb begin
        gnt       = '0;
        win_idx_s = last_q;
        cand_s    = last_q;
        found_s   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                gnt[cand_s] = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer next state: moves to the winner only when a grant is taken
    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = win_idx_s;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/spram64x32_rr_arb.sv
// Shares one 64x32 byte-maskable single-port SRAM among NUM_REQ requesters with
// round-robin grants and a two-stage, owner-tagged read return path.
module spram64x32_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = spram_arb_pkg::ADDR_W,
    parameter int DATA_W  = spram_arb_pkg::DATA_W,
    parameter int BE_W    = spram_arb_pkg::BE_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*BE_W-1:0]     req_be,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        sram_ceb,
    output logic                        sram_web,
    output logic [ADDR_W-1:0]           sram_a,
    output logic [DATA_W-1:0]           sram_d,
    output logic [BE_W-1:0]             sram_bweb,
    input  logic [DATA_W-1:0]           sram_q
);

    import spram_arb_pkg::*;

    logic [NUM_REQ-1:0] arb_req_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               adv_s;
    logic               sel_we_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic [BE_W-1:0]    sel_be_s;
    logic               rd_accept_s;

    logic               rd_vld_q,    rd_vld_d;
    logic [NUM_REQ-1:0] rd_own_q,    rd_own_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    // Nothing may be granted while reset is asserted
    assign arb_req_s = rst_n ? req_valid : {NUM_REQ{1'b0}};
    assign adv_s     = |gnt_s;
    assign req_ready = gnt_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req_s),
        .advance (adv_s),
        .gnt     (gnt_s)
    );

    // One-hot mux of the winning request fields
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_be_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_we_s    = req_we[i];
                sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
                sel_be_s    = req_be[i*BE_W +: BE_W];
            end else begin
                sel_we_s = sel_we_s;
            end
        end
    end

    // SRAM control encode; an all-zero byte-enable write is consumed without touching the array
    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        sram_bweb = SRAM_IDLE_BWEB;
        if (adv_s && !sel_we_s) begin
            sram_ceb = 1'b0;
            sram_a   = sel_addr_s;
            sram_d   = sel_wdata_s;
        end else if (adv_s && (sel_be_s != {BE_W{1'b0}})) begin
            sram_ceb  = 1'b0;
            sram_web  = 1'b0;
            sram_a    = sel_addr_s;
            sram_d    = sel_wdata_s;
            sram_bweb = ~sel_be_s;
        end else begin
            sram_ceb = 1'b1;
        end
    end

    assign rd_accept_s = adv_s & ~sel_we_s;

    // Read pipeline next state: stage 1 tags the owner, stage 2 releases data captured from Q
    always_comb begin
        rd_vld_d    = rd_accept_s;
        rd_own_d    = rd_accept_s ? gnt_s : {NUM_REQ{1'b0}};
        rsp_valid_d = rd_vld_q ? rd_own_q : {NUM_REQ{1'b0}};
        rsp_rdata_d = rd_vld_q ? sram_q : rsp_rdata_q;
    end

    // Read pipeline registers; reset drops any read in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q    <= 1'b0;
            rd_own_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rd_vld_q    <= rd_vld_d;
            rd_own_q    <= rd_own_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule : spram64x32_rr_arb

// File: tb/tb_spram64x32_rr_arb.sv
// Directed bench for spram64x32_rr_arb with a behavioural 64x32 byte-masked SRAM model.
module tb_spram64x32_rr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [31:0] rsp_rdata, sram_d, sram_q;
    logic        sram_ceb, sram_web;
    logic [5:0]  sram_a;
    logic [3:0]  sram_bweb;
    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram64x32_rr_arb #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_bweb (sram_bweb),
        .sram_q    (sram_q)
    );

    // SRAM model: write lanes with BWEB bit low, Q valid the cycle after a read
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) begin
                for (int k = 0; k < 4; k++) begin
                    if (!sram_bweb[k]) mem[sram_a][8*k +: 8] <= sram_d[8*k +: 8];
                end
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [1:0]  we;
        logic [5:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  b0, b1;
        logic [1:0]  e_rdy;
        logic        e_ceb, e_web;
        logic [5:0]  e_a;
        logic [31:0] e_d;
        logic [3:0]  e_bweb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [1:0] v, input logic [1:0] we,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1);
        rst_n     = r;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        req_be    = {b1, b0};
    endtask

    task automatic idle(input logic r);
        drv(r, 2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst   v      we     a0     a1     d0            d1            b0    b1    rdy    ceb   web   a      d             bweb
        vecs[0]  = '{1'b0, 2'b11, 2'b11, 6'd5,  6'd6,  32'h1,        32'h2,        4'hF, 4'hF, 2'b00, 1'b1, 1'b1, 6'd0,  32'h0,        4'hF};
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = '{1'b1, 2'b11, 2'b11, 6'd0,  6'd1,  32'hA,        32'hB,        4'hF, 4'hF, 2'b01, 1'b0, 1'b0, 6'd0,  32'hA,        4'h0};
        vecs[4]  = '{1'b1, 2'b11, 2'b11, 6'd0,  6'd1,  32'hA,        32'hB,        4'hF, 4'hF, 2'b10, 1'b0, 1'b0, 6'd1,  32'hB,        4'h0};
        vecs[5]  = '{1'b1, 2'b10, 2'b10, 6'd0,  6'd7,  32'h0,        32'h12345678, 4'h0, 4'hF, 2'b10, 1'b0, 1'b0, 6'd7,  32'h12345678, 4'h0};
        vecs[6]  = '{1'b1, 2'b01, 2'b01, 6'd63, 6'd0,  32'h11223344, 32'h0,        4'hF, 4'h0, 2'b01, 1'b0, 1'b0, 6'd63, 32'h11223344, 4'h0};
        vecs[7]  = '{1'b1, 2'b01, 2'b01, 6'd63, 6'd0,  32'hAABBCCDD, 32'h0,        4'h5, 4'h0, 2'b01, 1'b0, 1'b0, 6'd63, 32'hAABBCCDD, 4'hA};
        vecs[8]  = '{1'b1, 2'b10, 2'b10, 6'd0,  6'd7,  32'h0,        32'hCAFEF00D, 4'h0, 4'h0, 2'b10, 1'b1, 1'b1, 6'd0,  32'h0,        4'hF};
        vecs[9]  = '{1'b1, 2'b00, 2'b00, 6'd9,  6'd9,  32'h5,        32'h5,        4'hF, 4'hF, 2'b00, 1'b1, 1'b1, 6'd0,  32'h0,        4'hF};
        vecs[10] = '{1'b1, 2'b11, 2'b11, 6'd2,  6'd3,  32'h22,       32'h33,       4'hF, 4'hF, 2'b01, 1'b0, 1'b0, 6'd2,  32'h22,       4'h0};
        vecs[11] = '{1'b1, 2'b11, 2'b11, 6'd2,  6'd3,  32'h22,       32'h33,       4'hF, 4'hF, 2'b10, 1'b0, 1'b0, 6'd3,  32'h33,       4'h0};

        for (int i = 0; i < 12; i++) begin
            drv(vecs[i].rst, vecs[i].v, vecs[i].we, vecs[i].a0, vecs[i].a1,
                vecs[i].d0, vecs[i].d1, vecs[i].b0, vecs[i].b1);
            @(negedge clk);
            chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d ceb", i),   32'(sram_ceb),  32'(vecs[i].e_ceb));
            chk($sformatf("v%0d web", i),   32'(sram_web),  32'(vecs[i].e_web));
            chk($sformatf("v%0d a", i),     32'(sram_a),    32'(vecs[i].e_a));
            chk($sformatf("v%0d d", i),     sram_d,         vecs[i].e_d);
            chk($sformatf("v%0d bweb", i),  32'(sram_bweb), 32'(vecs[i].e_bweb));
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'h0);
            chk($sformatf("v%0d rsp_rdata", i), rsp_rdata,      32'h0);
            next_cycle();
        end

        // Write then read the same address on back-to-back cycles
        drv(1'b1, 2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
        @(negedge clk); chk("wr5 ready", 32'(req_ready), 32'h1);
        next_cycle();
        drv(1'b1, 2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk); chk("rd5 web", 32'(sram_web), 32'h1);
        chk("rd5 bweb", 32'(sram_bweb), 32'hF);
        next_cycle();
        idle(1'b1);
        @(negedge clk); chk("rd5 t+1 rsp_valid", 32'(rsp_valid), 32'h0);
        next_cycle();
        @(negedge clk); chk("rd5 rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd5 rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk); chk("rd5 one-shot", 32'(rsp_valid), 32'h0);
        chk("rd5 rdata hold", rsp_rdata, 32'hDEADBEEF);
        next_cycle();

        // Byte-masked merge at the top address
        drv(1'b1, 2'b01, 2'b00, 6'd63, 6'd0, 32'h0, 32'h0, 4'h0, 4'h0);
        next_cycle(); idle(1'b1); next_cycle();
        @(negedge clk); chk("mask rsp_valid", 32'(rsp_valid), 32'h1);
        chk("mask rsp_rdata", rsp_rdata, 32'h11BB33DD);
        next_cycle();

        // Zero-byte-enable write left address 7 untouched
        drv(1'b1, 2'b10, 2'b00, 6'd0, 6'd7, 32'h0, 32'h0, 4'h0, 4'h0);
        next_cycle(); idle(1'b1); next_cycle();
        @(negedge clk); chk("be0 rsp_valid", 32'(rsp_valid), 32'h2);
        chk("be0 rsp_rdata", rsp_rdata, 32'h12345678);
        next_cycle();

        // Contention: both read continuously, grants and responses alternate
        for (int k = 0; k < 8; k++) begin
            if (k < 6) drv(1'b1, 2'b11, 2'b00, 6'd0, 6'd1, 32'h0, 32'h0, 4'h0, 4'h0);
            else       idle(1'b1);
            @(negedge clk);
            if (k < 6) begin
                chk($sformatf("cont%0d ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("cont%0d ceb", k), 32'(sram_ceb), 32'h0);
            end else begin
                chk($sformatf("cont%0d ready", k), 32'(req_ready), 32'h0);
            end
            if (k >= 2) begin
                chk($sformatf("cont%0d rsp_valid", k), 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("cont%0d rsp_rdata", k), rsp_rdata, (k % 2 == 0) ? 32'hA : 32'hB);
            end else begin
                chk($sformatf("cont%0d rsp_valid", k), 32'(rsp_valid), 32'h0);
            end
            next_cycle();
        end

        // Reset one cycle after a read is accepted: the response must never appear
        drv(1'b1, 2'b01, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk); chk("rst-mid ready", 32'(req_ready), 32'h1);
        next_cycle();
        drv(1'b0, 2'b11, 2'b00, 6'd0, 6'd1, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk); chk("rst-mid ready in reset", 32'(req_ready), 32'h0);
        chk("rst-mid ceb in reset", 32'(sram_ceb), 32'h1);
        next_cycle();
        idle(1'b1);
        @(negedge clk); chk("rst-mid t+2 rsp_valid", 32'(rsp_valid), 32'h0);
        next_cycle();
        @(negedge clk); chk("rst-mid t+3 rsp_valid", 32'(rsp_valid), 32'h0);
        next_cycle();
        drv(1'b1, 2'b11, 2'b11, 6'd10, 6'd11, 32'h0, 32'h0, 4'hF, 4'hF);
        @(negedge clk); chk("post-reset first grant", 32'(req_ready), 32'h1);
        next_cycle();
        idle(1'b1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spram64x32_rr_arb
